// File: rtl/gpio_in_pkg.sv
// Shared constants, edge-mode encodings and edge qualification helper for the
// gpio_in_capture peripheral.
package gpio_in_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned MODE_CFG_BITS = 16;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_mode_e;

    // Returns 1 when the observed transition matches the selected edge mode.
    function automatic logic edge_hit(input logic [1:0] mode,
                                      input logic       rise,
                                      input logic       fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_ANY:  hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_in_debounce.sv
// Single-bit input conditioner: multi-flop synchroniser followed by an
// optional stability filter that rejects pulses shorter than DEBOUNCE_CYCLES.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign dout = sync_bit;
    end else begin : g_filter
        localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q;
        logic             filt_q;

        // Counter runs only while the synchronised input disagrees with the
        // filtered value; any return to agreement restarts the qualification.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else if (sync_bit != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_q <= sync_bit;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign dout = filt_q;
    end

endmodule

// File: rtl/gpio_in_capture.sv
// Parametrised Avalon-MM input port with synchronised/debounced inputs,
// per-bit selectable edge capture and a maskable level interrupt.
module gpio_in_capture
    import gpio_in_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned BIT_CLEAR       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned MODE_BITS = (WIDTH <= MODE_CFG_BITS) ? 2 * WIDTH : 2 * MODE_CFG_BITS;

    logic [WIDTH-1:0]     filtered;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     capture_q;
    logic [WIDTH-1:0]     mask_q;
    logic [MODE_BITS-1:0] mode_q;
    logic [WIDTH-1:0]     edge_det_c;
    logic [WIDTH-1:0]     clear_c;
    logic [BUS_W-1:0]     rdata_c;
    logic                 wr_en_c;
    logic                 unused_wdata;

    assign wr_en_c      = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        logic [1:0] bit_mode;

        gpio_in_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .din  (in_port[gi]),
            .dout (filtered[gi])
        );

        // Only the low 16 bits have a mode field; any higher bit is fixed rising.
        if (gi < int'(MODE_CFG_BITS)) begin : g_cfg
            assign bit_mode = mode_q[2*gi +: 2];
        end else begin : g_fixed
            assign bit_mode = EDGE_RISE;
        end

        assign edge_det_c[gi] = edge_hit(bit_mode,
                                         filtered[gi] & ~prev_q[gi],
                                         ~filtered[gi] & prev_q[gi]);
    end

    // Bits to clear on this cycle's capture-register write.
    always_comb begin
        clear_c = '0;
        if (wr_en_c && (address == ADDR_CAPTURE)) begin
            if (BIT_CLEAR != 0) begin
                clear_c = writedata[WIDTH-1:0];
            end else begin
                clear_c = '1;
            end
        end
    end

    always_comb begin
        rdata_c = '0;
        case (address)
            ADDR_DATA:    rdata_c = BUS_W'(filtered);
            ADDR_MODE:    rdata_c = BUS_W'(mode_q);
            ADDR_MASK:    rdata_c = BUS_W'(mask_q);
            ADDR_CAPTURE: rdata_c = BUS_W'(capture_q);
            default:      rdata_c = '0;
        endcase
    end

    // New edges take priority over a same-cycle clear so no event is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            capture_q <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
        end else begin
            prev_q    <= filtered;
            capture_q <= edge_det_c | (capture_q & ~clear_c);
            irq       <= |(capture_q & mask_q);
            readdata  <= rdata_c;
            if (wr_en_c && (address == ADDR_MODE)) begin
                mode_q <= writedata[MODE_BITS-1:0];
            end
            if (wr_en_c && (address == ADDR_MASK)) begin
                mask_q <= writedata[WIDTH-1:0];
            end
        end
    end

endmodule
